proc_reset_step_ctrl: RTL and testbench

//   Synthesizable clock-enable and reset sequencer for the single-cycle LEGv8 core.

---
 rtl/proc_reset_step_ctrl_if.sv | 27 ++
 rtl/proc_reset_step_ctrl.sv | 146 ++++++++++++++
 tb/tb_proc_reset_step_ctrl.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/proc_reset_step_ctrl_if.sv
// Control inputs and status outputs of the reset/step sequencer.
// The master drives the requests; the slave (sequencer) drives the status.
interface proc_reset_step_ctrl_if #(
  parameter int unsigned NUM_DOMAINS = 2,
  parameter int unsigned CNT_W       = 32
);
  logic                   soft_rst;
  logic                   run;
  logic                   halt_req;
  logic                   step;
  logic [NUM_DOMAINS-1:0] core_rst;
  logic                   core_ce;
  logic                   rst_done;
  logic [1:0]             state;
  logic                   step_ack;
  logic [CNT_W-1:0]       cycle_cnt;

  modport master (
    output soft_rst, run, halt_req, step,
    input  core_rst, core_ce, rst_done, state, step_ack, cycle_cnt
  );

  modport slave (
    input  soft_rst, run, halt_req, step,
    output core_rst, core_ce, rst_done, state, step_ack, cycle_cnt
  );
endinterface

// File: rtl/proc_reset_step_ctrl.sv
// Clock-enable and reset sequencer for the single-cycle core: staggered
// per-domain reset release, run/halt/single-step control, enabled-cycle count.
module proc_reset_step_ctrl #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RST_CYCLES  = 4,
  parameter int unsigned NUM_DOMAINS = 2,
  parameter int unsigned STAGGER     = 2,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  Reset_n,
  proc_reset_step_ctrl_if.slave bus
);

  localparam int unsigned RC_W = $clog2(RST_CYCLES) + 1;
  localparam int unsigned SG_W = $clog2(STAGGER) + 1;
  localparam logic [NUM_DOMAINS-1:0] ALL_RST   = {NUM_DOMAINS{1'b1}};
  localparam logic [NUM_DOMAINS-1:0] FIRST_REL = {NUM_DOMAINS{1'b1}} << 1;

  typedef enum logic [1:0] {
    ST_RESET   = 2'd0,
    ST_RELEASE = 2'd1,
    ST_HALT    = 2'd2,
    ST_RUN     = 2'd3
  } state_e;

  state_e                 st;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   step_q;
  logic [RC_W-1:0]        rst_cnt;
  logic [SG_W-1:0]        stg_cnt;
  logic [NUM_DOMAINS-1:0] core_rst;
  logic                   core_ce;
  logic                   rst_done;
  logic                   step_ack;
  logic [CNT_W-1:0]       cycle_cnt;

  logic                   rst_sync;
  logic                   hold;
  logic                   step_rise;
  logic [NUM_DOMAINS-1:0] rst_shl;

  assign rst_sync  = sync_q[SYNC_STAGES-1];
  assign hold      = bus.halt_req | ~bus.run;
  assign step_rise = bus.step & ~step_q;
  assign rst_shl   = core_rst << 1;

  // Reset deassertion synchronizer; assertion stays asynchronous.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
  end

  // Step edge detector keeps tracking in every state, so a step held through RUN is not replayed.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) step_q <= 1'b0;
    else          step_q <= bus.step;
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      st        <= ST_RESET;
      rst_cnt   <= '0;
      stg_cnt   <= '0;
      core_rst  <= ALL_RST;
      core_ce   <= 1'b0;
      rst_done  <= 1'b0;
      step_ack  <= 1'b0;
      cycle_cnt <= '0;
    end else if (bus.soft_rst) begin
      st        <= ST_RESET;
      rst_cnt   <= '0;
      stg_cnt   <= '0;
      core_rst  <= ALL_RST;
      core_ce   <= 1'b0;
      rst_done  <= 1'b0;
      step_ack  <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      step_ack <= 1'b0;
      if (core_ce) cycle_cnt <= cycle_cnt + CNT_W'(1);
      case (st)
        ST_RESET: begin
          if (!rst_sync) begin
            rst_cnt <= '0;
          end else if (rst_cnt == RC_W'(RST_CYCLES)) begin
            rst_cnt  <= '0;
            stg_cnt  <= '0;
            core_rst <= FIRST_REL;
            // A single domain is fully released on the entry edge.
            if (FIRST_REL == '0) begin
              rst_done <= 1'b1;
              core_ce  <= ~hold;
              st       <= hold ? ST_HALT : ST_RUN;
            end else begin
              st <= ST_RELEASE;
            end
          end else begin
            rst_cnt <= rst_cnt + RC_W'(1);
          end
        end
        ST_RELEASE: begin
          if (stg_cnt == SG_W'(STAGGER - 1)) begin
            stg_cnt  <= '0;
            core_rst <= rst_shl;
            if (rst_shl == '0) begin
              rst_done <= 1'b1;
              core_ce  <= ~hold;
              st       <= hold ? ST_HALT : ST_RUN;
            end
          end else begin
            stg_cnt <= stg_cnt + SG_W'(1);
          end
        end
        ST_RUN: begin
          if (hold) begin
            st      <= ST_HALT;
            core_ce <= 1'b0;
          end else begin
            core_ce <= 1'b1;
          end
        end
        ST_HALT: begin
          // Resuming run wins over a step arriving on the same edge.
          if (!hold) begin
            st      <= ST_RUN;
            core_ce <= 1'b1;
          end else if (step_rise) begin
            core_ce  <= 1'b1;
            step_ack <= 1'b1;
          end else begin
            core_ce <= 1'b0;
          end
        end
      endcase
    end
  end

  assign bus.core_rst  = core_rst;
  assign bus.core_ce   = core_ce;
  assign bus.rst_done  = rst_done;
  assign bus.state     = st;
  assign bus.step_ack  = step_ack;
  assign bus.cycle_cnt = cycle_cnt;

endmodule

// File: tb/tb_proc_reset_step_ctrl.sv
// Directed bench for proc_reset_step_ctrl: default instance plus a CNT_W=4
// instance sharing the same inputs to exercise counter wrap.
module tb_proc_reset_step_ctrl;

  logic clk = 1'b0;
  logic Reset_n;
  int   checks = 0;
  int   errors = 0;
  int   ce_pulses = 0;
  int   ack_pulses = 0;

  always #5 clk = ~clk;

  proc_reset_step_ctrl_if #(.NUM_DOMAINS(2), .CNT_W(32)) bus ();
  proc_reset_step_ctrl_if #(.NUM_DOMAINS(2), .CNT_W(4))  bus4 ();

  assign bus4.soft_rst = bus.soft_rst;
  assign bus4.run      = bus.run;
  assign bus4.halt_req = bus.halt_req;
  assign bus4.step     = bus.step;

  proc_reset_step_ctrl #(
    .SYNC_STAGES(2), .RST_CYCLES(4), .NUM_DOMAINS(2), .STAGGER(2), .CNT_W(32)
  ) dut (
    .clk     (clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  proc_reset_step_ctrl #(
    .SYNC_STAGES(2), .RST_CYCLES(4), .NUM_DOMAINS(2), .STAGGER(2), .CNT_W(4)
  ) dut4 (
    .clk     (clk),
    .Reset_n (Reset_n),
    .bus     (bus4)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and sample 1ns after each.
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      ce_pulses  += int'(bus.core_ce);
      ack_pulses += int'(bus.step_ack);
    end
  endtask

  initial begin
    Reset_n      = 1'b0;
    bus.soft_rst = 1'b0;
    bus.run      = 1'b1;
    bus.halt_req = 1'b0;
    bus.step     = 1'b0;

    // Test 1: power-on release, edges counted from first edge seeing Reset_n high
    ticks(3);
    check("rst_core_rst", 64'(bus.core_rst), 64'd3);
    check("rst_core_ce", 64'(bus.core_ce), 64'd0);
    check("rst_done", 64'(bus.rst_done), 64'd0);
    check("rst_state", 64'(bus.state), 64'd0);
    check("rst_cycle_cnt", 64'(bus.cycle_cnt), 64'd0);
    check("rst_step_ack", 64'(bus.step_ack), 64'd0);
    Reset_n = 1'b1;
    ticks(6);   // E5
    check("t1_e5_core_rst", 64'(bus.core_rst), 64'd3);
    check("t1_e5_state", 64'(bus.state), 64'd0);
    ticks(1);   // E6
    check("t1_e6_core_rst", 64'(bus.core_rst), 64'd2);
    check("t1_e6_state", 64'(bus.state), 64'd1);
    check("t1_e6_rst_done", 64'(bus.rst_done), 64'd0);
    ticks(1);   // E7
    check("t1_e7_core_rst", 64'(bus.core_rst), 64'd2);
    ticks(1);   // E8
    check("t1_e8_core_rst", 64'(bus.core_rst), 64'd0);
    check("t1_e8_rst_done", 64'(bus.rst_done), 64'd1);
    check("t1_e8_state", 64'(bus.state), 64'd3);
    check("t1_e8_core_ce", 64'(bus.core_ce), 64'd1);
    check("t1_e8_cycle_cnt", 64'(bus.cycle_cnt), 64'd0);
    ticks(1);   // E9
    check("t1_e9_cycle_cnt", 64'(bus.cycle_cnt), 64'd1);

    // Test 5: narrow counter wraps 15 -> 0
    ticks(14);  // E23
    check("t5_e23_cnt4", 64'(bus4.cycle_cnt), 64'd15);
    ticks(1);   // E24
    check("t5_e24_cnt4", 64'(bus4.cycle_cnt), 64'd0);
    check("t5_e24_cnt32", 64'(bus.cycle_cnt), 64'd16);
    ticks(4);   // E28
    check("t5_e28_cnt4", 64'(bus4.cycle_cnt), 64'd4);
    check("t5_e28_cnt32", 64'(bus.cycle_cnt), 64'd20);

    // Test 2: halt_req with run still high stops at once
    bus.halt_req = 1'b1;
    ticks(1);   // E29
    check("t2_e29_state", 64'(bus.state), 64'd2);
    check("t2_e29_core_ce", 64'(bus.core_ce), 64'd0);
    check("t2_e29_cycle_cnt", 64'(bus.cycle_cnt), 64'd21);
    bus.halt_req = 1'b0;
    bus.run      = 1'b0;
    ticks(3);   // E32
    check("t2_e32_state", 64'(bus.state), 64'd2);
    check("t2_e32_core_ce", 64'(bus.core_ce), 64'd0);
    check("t2_e32_cycle_cnt", 64'(bus.cycle_cnt), 64'd21);
    check("t2_e32_cnt4", 64'(bus4.cycle_cnt), 64'd5);

    // Test 3: step held 5 cycles, low 1, high 1
    bus.step   = 1'b1;
    ce_pulses  = 0;
    ack_pulses = 0;
    ticks(1);   // E33
    check("t3_e33_step_ack", 64'(bus.step_ack), 64'd1);
    check("t3_e33_core_ce", 64'(bus.core_ce), 64'd1);
    ticks(1);   // E34
    check("t3_e34_core_ce", 64'(bus.core_ce), 64'd0);
    ticks(3);   // E37
    bus.step = 1'b0;
    ticks(1);   // E38
    bus.step = 1'b1;
    ticks(1);   // E39
    check("t3_e39_step_ack", 64'(bus.step_ack), 64'd1);
    bus.step = 1'b0;
    ticks(1);   // E40
    check("t3_ce_pulses", 64'(ce_pulses), 64'd2);
    check("t3_ack_pulses", 64'(ack_pulses), 64'd2);
    check("t3_cycle_cnt", 64'(bus.cycle_cnt), 64'd23);
    check("t3_state", 64'(bus.state), 64'd2);

    // Resume run wins over a simultaneous step
    bus.run  = 1'b1;
    bus.step = 1'b1;
    ticks(1);   // E41
    check("resume_state", 64'(bus.state), 64'd3);
    check("resume_step_ack", 64'(bus.step_ack), 64'd0);
    check("resume_core_ce", 64'(bus.core_ce), 64'd1);
    check("resume_cycle_cnt", 64'(bus.cycle_cnt), 64'd23);
    bus.step = 1'b0;
    ticks(1);   // E42
    check("resume_cnt_inc", 64'(bus.cycle_cnt), 64'd24);

    // Test 4: soft reset from RUN, then again mid-RELEASE (held 3 edges)
    bus.soft_rst = 1'b1;
    ticks(1);   // E43
    check("t4_soft_state", 64'(bus.state), 64'd0);
    check("t4_soft_core_rst", 64'(bus.core_rst), 64'd3);
    check("t4_soft_cycle_cnt", 64'(bus.cycle_cnt), 64'd0);
    check("t4_soft_core_ce", 64'(bus.core_ce), 64'd0);
    check("t4_soft_rst_done", 64'(bus.rst_done), 64'd0);
    bus.soft_rst = 1'b0;
    ticks(4);   // E47
    check("t4_e47_core_rst", 64'(bus.core_rst), 64'd3);
    ticks(1);   // E48
    check("t4_e48_core_rst", 64'(bus.core_rst), 64'd2);
    check("t4_e48_state", 64'(bus.state), 64'd1);
    bus.soft_rst = 1'b1;
    ticks(1);   // E49
    check("t4_mid_core_rst", 64'(bus.core_rst), 64'd3);
    ticks(2);   // E51
    check("t4_held_state", 64'(bus.state), 64'd0);
    bus.soft_rst = 1'b0;
    ticks(4);   // E55
    check("t4_e55_core_rst", 64'(bus.core_rst), 64'd3);
    ticks(1);   // E56
    check("t4_e56_core_rst", 64'(bus.core_rst), 64'd2);
    ticks(2);   // E58
    check("t4_e58_core_rst", 64'(bus.core_rst), 64'd0);
    check("t4_e58_rst_done", 64'(bus.rst_done), 64'd1);
    check("t4_e58_state", 64'(bus.state), 64'd3);
    check("t4_e58_cycle_cnt", 64'(bus.cycle_cnt), 64'd0);
    ticks(1);   // E59
    check("t4_e59_cycle_cnt", 64'(bus.cycle_cnt), 64'd1);

    // Test 6: asynchronous reset mid-cycle in RUN
    #3;
    Reset_n = 1'b0;
    #1;
    check("t6_async_core_rst", 64'(bus.core_rst), 64'd3);
    check("t6_async_core_ce", 64'(bus.core_ce), 64'd0);
    check("t6_async_state", 64'(bus.state), 64'd0);
    check("t6_async_cycle_cnt", 64'(bus.cycle_cnt), 64'd0);
    check("t6_async_rst_done", 64'(bus.rst_done), 64'd0);
    ticks(2);
    Reset_n = 1'b1;
    ticks(6);   // E5
    check("t6_e5_core_rst", 64'(bus.core_rst), 64'd3);
    ticks(1);   // E6
    check("t6_e6_core_rst", 64'(bus.core_rst), 64'd2);
    ticks(2);   // E8
    check("t6_e8_core_rst", 64'(bus.core_rst), 64'd0);
    check("t6_e8_rst_done", 64'(bus.rst_done), 64'd1);
    check("t6_e8_core_ce", 64'(bus.core_ce), 64'd1);
    check("t6_e8_cnt4", 64'(bus4.cycle_cnt), 64'd0);
    ticks(1);   // E9
    check("t6_e9_cycle_cnt", 64'(bus.cycle_cnt), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
